// File: rtl/wide_add_seq_if.sv
// wide_add_seq_if
//   Operand/result handshake bundle for the multi-cycle wide adder.
//   master : requester/consumer side (drives operands, out_ready)
//   slave  : adder side (drives in_ready, result and flags)
//   Signals: in_valid/in_ready + a, b, cin, sub   (operand channel)
//            out_valid/out_ready + s, cout, ovf   (result channel)
interface wide_add_seq_if #(
  parameter int N = 256
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] s;
  logic         cout;
  logic         ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, s, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, s, cout, ovf
  );
endinterface

// File: rtl/wide_add_seq.sv
// wide_add_seq
//   Multi-cycle N-bit adder/subtractor built from a single K-bit ripple
//   slice, stepped over BEATS = N/K cycles, least significant chunk first,
//   with the inter-chunk carry kept in a register.
//   Ports:
//     clk   : rising-edge clock
//     rst_n : synchronous active-low reset
//     bus   : wide_add_seq_if.slave (operand and result handshakes)
//   N must be a multiple of K, and N/K must be at least 2.
module wide_add_seq #(
  parameter int N = 256,
  parameter int K = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  wide_add_seq_if.slave     bus
);
  localparam int BEATS = N / K;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_reg;
  logic [N-1:0]   opa_reg;
  logic [N-1:0]   opb_reg;
  logic [N-1:0]   s_reg;
  logic           c_reg;
  logic           cout_reg;
  logic           ovf_reg;
  logic [BW-1:0]  beat_reg;

  logic [K-1:0]   slice_a;
  logic [K-1:0]   slice_b;
  logic [K-1:0]   slice_sum;
  logic [K:0]     carry;
  logic           slice_cout;
  logic           last_beat;

  // Current chunk of each operand feeds the shared slice.
  assign slice_a   = opa_reg[beat_reg*K +: K];
  assign slice_b   = opb_reg[beat_reg*K +: K];
  assign last_beat = (beat_reg == BW'(BEATS - 1));

  // K-bit ripple slice; its carry-in is only ever the chained carry register.
  assign carry[0] = c_reg;
  generate
    for (genvar gi = 0; gi < K; gi++) begin : g_fa
      assign slice_sum[gi] = slice_a[gi] ^ slice_b[gi] ^ carry[gi];
      assign carry[gi+1]   = (slice_a[gi] & slice_b[gi]) |
                             (carry[gi] & (slice_a[gi] ^ slice_b[gi]));
    end
  endgenerate
  assign slice_cout = carry[K];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      s_reg     <= '0;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
      c_reg     <= 1'b0;
      beat_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.in_valid) begin
            // Subtraction is a + ~b + 1: invert b here, inject the +1 as carry.
            opa_reg   <= bus.a;
            opb_reg   <= bus.sub ? ~bus.b : bus.b;
            c_reg     <= bus.sub ? 1'b1 : bus.cin;
            beat_reg  <= '0;
            state_reg <= RUN;
          end
        end
        RUN: begin
          s_reg[beat_reg*K +: K] <= slice_sum;
          c_reg                  <= slice_cout;
          if (last_beat) begin
            cout_reg  <= slice_cout;
            // Carry into the MSB xor carry out of the MSB.
            ovf_reg   <= opa_reg[N-1] ^ opb_reg[N-1] ^ slice_sum[K-1] ^ slice_cout;
            state_reg <= DONE;
          end else begin
            beat_reg  <= beat_reg + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Handshake outputs come from registered state; rst_n only masks in_ready
  // so nothing is taken while reset is being held.
  assign bus.in_ready  = rst_n && (state_reg == IDLE);
  assign bus.out_valid = (state_reg == DONE);
  assign bus.s         = s_reg;
  assign bus.cout      = cout_reg;
  assign bus.ovf       = ovf_reg;
endmodule

// File: tb/tb_wide_add_seq.sv
// tb_wide_add_seq
//   Self-checking bench for wide_add_seq (N=256, K=64): directed corner
//   cases, randomized operations against a plain-arithmetic model,
//   backpressure and mid-operation reset abort.
module tb_wide_add_seq;
  localparam int N     = 256;
  localparam int K     = 64;
  localparam int BEATS = N / K;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_miss;

  wide_add_seq_if #(.N(N)) bus ();

  wide_add_seq #(.N(N), .K(K)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [N:0] got, input logic [N:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s got %h want %h", tag, got, exp);
    end
  endtask

  // Reference: full-width arithmetic with one extra bit for the carry.
  task automatic model(input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic cin, input logic sub,
                       output logic [N-1:0] s, output logic co, output logic ov);
    logic [N-1:0] bb;
    logic [N:0]   full;
    bb   = sub ? ~b : b;
    full = {1'b0, a} + {1'b0, bb} + (N+1)'(sub ? 1'b1 : cin);
    s    = full[N-1:0];
    co   = full[N];
    ov   = (a[N-1] == bb[N-1]) && (full[N-1] != a[N-1]);
  endtask

  function automatic logic [N-1:0] rand_wide();
    logic [N-1:0] r;
    for (int i = 0; i < N/32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [N-1:0] rand_operand();
    logic [N-1:0] r;
    logic [N-1:0] one;
    one = 1;
    case ($urandom_range(0, 5))
      0:       r = '1;
      1:       r = '0;
      2:       r = one << (N-1);
      3:       r = (one << (N-1)) - 1;
      default: r = rand_wide();
    endcase
    return r;
  endfunction

  // Assumes out_ready=1 and the block idle on entry; leaves it idle.
  task automatic run_op(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic cin, input logic sub);
    logic [N-1:0] es;
    logic         eco, eov;
    int           cyc;
    model(a, b, cin, sub, es, eco, eov);
    check({tag, ".ready"}, (N+1)'(bus.in_ready), (N+1)'(1));
    bus.a = a; bus.b = b; bus.cin = cin; bus.sub = sub; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    // Operands are free to change after accept.
    bus.a = rand_wide(); bus.b = rand_wide(); bus.cin = ~cin; bus.sub = ~sub;
    check({tag, ".busy"}, (N+1)'(bus.in_ready), (N+1)'(0));
    cyc = 0;
    while (!bus.out_valid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, ".lat"}, (N+1)'(cyc), (N+1)'(BEATS));
    check({tag, ".s"},    {1'b0, bus.s},   {1'b0, es});
    check({tag, ".cout"}, (N+1)'(bus.cout), (N+1)'(eco));
    check({tag, ".ovf"},  (N+1)'(bus.ovf),  (N+1)'(eov));
    $display("op %s sub=%0d cin=%0d lat=%0d cout=%0d ovf=%0d", tag, sub, cin, cyc, bus.cout, bus.ovf);
    @(posedge clk); #1;
    check({tag, ".back"}, (N+1)'({bus.in_ready, bus.out_valid}), (N+1)'(2'b10));
  endtask

  initial begin
    logic [N-1:0] one, all1, e_s, a2, b2, hold_s;
    logic         e_co, e_ov, hold_c, saw_valid;
    int           cyc;
    n_vec = 0; n_miss = 0;
    one  = 1;
    all1 = '1;
    rst_n = 1'b0;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    bus.a = all1; bus.b = one; bus.cin = 1'b1; bus.sub = 1'b0;

    // Reset held 3 cycles with a pending request.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("rst.in_ready",  (N+1)'(bus.in_ready),  (N+1)'(0));
      check("rst.out_valid", (N+1)'(bus.out_valid), (N+1)'(0));
      check("rst.s",         {1'b0, bus.s},         '0);
      check("rst.flags",     (N+1)'({bus.cout, bus.ovf}), (N+1)'(0));
    end
    rst_n = 1'b1; bus.in_valid = 1'b0;
    #1;
    check("rel.in_ready", (N+1)'(bus.in_ready), (N+1)'(1));
    @(posedge clk); #1;
    check("rel.no_accept", (N+1)'(bus.in_ready), (N+1)'(1));
    $display("reset sequence done");

    // Directed corner cases.
    run_op("ripple",  all1, one, 1'b0, 1'b0);
    run_op("chunk64", (one << 64) - 1, '0, 1'b1, 1'b0);
    run_op("chunk128", (one << 128) - 1, (one << 128) - 1, 1'b0, 1'b0);
    run_op("sub5_7",  N'(5), N'(7), 1'b1, 1'b1);
    run_op("sub7_5",  N'(7), N'(5), 1'b0, 1'b1);
    run_op("submin",  one << (N-1), one, 1'b0, 1'b1);
    run_op("ovfadd",  (one << (N-1)) - 1, one, 1'b0, 1'b0);

    // Randomized operations.
    for (int i = 0; i < 40; i++) begin
      run_op($sformatf("rnd%0d", i), rand_operand(), rand_operand(),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Backpressure: result held in DONE while a new request waits.
    bus.out_ready = 1'b0;
    model(N'(123), all1, 1'b1, 1'b0, e_s, e_co, e_ov);
    bus.a = N'(123); bus.b = all1; bus.cin = 1'b1; bus.sub = 1'b0; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    a2 = rand_wide(); b2 = rand_wide();
    bus.a = a2; bus.b = b2; bus.cin = 1'b0; bus.sub = 1'b1;
    cyc = 0;
    while (!bus.out_valid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("bp.lat", (N+1)'(cyc), (N+1)'(BEATS));
    hold_s = bus.s; hold_c = bus.cout;
    check("bp.s", {1'b0, hold_s}, {1'b0, e_s});
    check("bp.cout", (N+1)'(hold_c), (N+1)'(e_co));
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp.hold", (N+1)'({bus.out_valid, bus.in_ready}), (N+1)'(2'b10));
      check("bp.stable", {bus.cout, bus.s}, {e_co, e_s});
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("bp.release", (N+1)'({bus.out_valid, bus.in_ready}), (N+1)'(2'b01));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("bp.accept", (N+1)'(bus.in_ready), (N+1)'(0));
    model(a2, b2, 1'b0, 1'b1, e_s, e_co, e_ov);
    cyc = 0;
    while (!bus.out_valid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("bp2.lat", (N+1)'(cyc), (N+1)'(BEATS));
    check("bp2.s", {bus.cout, bus.s}, {e_co, e_s});
    check("bp2.ovf", (N+1)'(bus.ovf), (N+1)'(e_ov));
    $display("op backpressure done cout=%0d ovf=%0d", bus.cout, bus.ovf);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;

    // Abort: reset pulse while beat 2 is in flight.
    bus.a = rand_wide(); bus.b = rand_wide(); bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    saw_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) saw_valid = 1'b1;
    end
    check("abort.no_result", (N+1)'(saw_valid), (N+1)'(0));
    check("abort.idle", (N+1)'(bus.in_ready), (N+1)'(1));
    $display("op abort done");
    run_op("post_abort", rand_wide(), rand_wide(), 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
